object_pixel_source: RTL

// - Per-pixel object (fruit/blade sprite) layer generator: for the VGA pixel (pix_x,pix_y) it emits the 12-bit RGB object colour datao consumed by the object/background mixer.
// - datao==12'h000 means transparent; the mixer then shows the background per channel. Sprite art must therefore never use 12'h000 as a visible colour.
// - Holds a double-buffered object table: game logic writes a shadow copy; the shadow copy is committed at frame start, so no tearing mid-frame.

---
 rtl/object_pixel_source_pkg.sv | 19 +
 rtl/object_pixel_source_hit_test.sv | 52 +++++
 rtl/object_pixel_source.sv | 111 +++++++++++
 3 files changed

// File: rtl/object_pixel_source_pkg.sv
// Shared constants and object-slot layout for the object pixel layer.
// Imported by the hit tester and the top.
package object_pixel_source_pkg;

  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam logic [11:0] TRANSPARENT = 12'h000;

  localparam int COORD_W = 10;
  localparam int SPR_IDX_W = 3;

  typedef struct packed {
    logic                 active;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic [SPR_IDX_W-1:0] sprite;
  } obj_t;

endpackage

// File: rtl/object_pixel_source_hit_test.sv
// Combinational bounds compare of one pixel against all slots.
// Lowest-index hit wins and supplies sprite and in-sprite offset.
module obj_hit_test
  import object_pixel_source_pkg::*;
#(
  parameter int NOBJ  = 4,
  parameter int SPR_W = 64,
  parameter int SPR_H = 64,
  localparam int DX_W = $clog2(SPR_W),
  localparam int DY_W = $clog2(SPR_H)
) (
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  obj_t [NOBJ-1:0]       objs,
  output logic                  hit,
  output logic [SPR_IDX_W-1:0]  spr,
  output logic [DX_W-1:0]       dx,
  output logic [DY_W-1:0]       dy
);

  logic [10:0] ex;
  logic [10:0] ey;
  logic        in_x;
  logic        in_y;

  always_comb begin
    hit  = 1'b0;
    spr  = '0;
    dx   = '0;
    dy   = '0;
    ex   = '0;
    ey   = '0;
    in_x = 1'b0;
    in_y = 1'b0;
    // Walk from lowest priority up so the lowest index overwrites last.
    for (int i = NOBJ - 1; i >= 0; i--) begin
      ex   = {1'b0, pix_x} - {1'b0, objs[i].x};
      ey   = {1'b0, pix_y} - {1'b0, objs[i].y};
      in_x = (pix_x >= objs[i].x) &&
             ({1'b0, pix_x} < ({1'b0, objs[i].x} + 11'(SPR_W)));
      in_y = (pix_y >= objs[i].y) &&
             ({1'b0, pix_y} < ({1'b0, objs[i].y} + 11'(SPR_H)));
      if (objs[i].active && in_x && in_y) begin
        hit = 1'b1;
        spr = objs[i].sprite;
        dx  = ex[DX_W-1:0];
        dy  = ey[DY_W-1:0];
      end
    end
  end

endmodule

// File: rtl/object_pixel_source.sv
// Object layer: double-buffered slot table and 3-stage pixel pipeline
// (hit test -> sprite ROM read -> colour register).
module object_pixel_source
  import object_pixel_source_pkg::*;
#(
  parameter int NOBJ   = 4,
  parameter int NSPR   = 8,
  parameter int SPR_W  = 64,
  parameter int SPR_H  = 64,
  parameter int ADDR_W = 15
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    pix_en,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic                    frame_start,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [$clog2(NOBJ)-1:0] upd_idx,
  input  logic [9:0]              upd_x,
  input  logic [9:0]              upd_y,
  input  logic [$clog2(NSPR)-1:0] upd_sprite,
  input  logic                    upd_active,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [11:0]             rom_data,
  output logic [11:0]             datao,
  output logic                    datao_valid
);

  localparam int DX_W = $clog2(SPR_W);
  localparam int DY_W = $clog2(SPR_H);

  obj_t [NOBJ-1:0] shadow_q, shadow_d;
  obj_t [NOBJ-1:0] active_q, active_d;

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit1_q, hit1_d;
  logic              v1_q, v1_d;
  logic              hit2_q, hit2_d;
  logic              v2_q, v2_d;
  logic [11:0]       datao_q, datao_d;
  logic              dv_q, dv_d;

  logic                 hit;
  logic [SPR_IDX_W-1:0] spr;
  logic [DX_W-1:0]      dx;
  logic [DY_W-1:0]      dy;

  obj_hit_test #(
    .NOBJ (NOBJ),
    .SPR_W(SPR_W),
    .SPR_H(SPR_H)
  ) u_hit (
    .pix_x(pix_x),
    .pix_y(pix_y),
    .objs (active_q),
    .hit  (hit),
    .spr  (spr),
    .dx   (dx),
    .dy   (dy)
  );

  // A write offered during the commit cycle waits one cycle.
  assign upd_ready = !frame_start;

  always_comb begin
    shadow_d = shadow_q;
    if (upd_valid && upd_ready) begin
      shadow_d[upd_idx] = {upd_active, upd_x, upd_y, upd_sprite};
    end
    active_d = frame_start ? shadow_q : active_q;

    rom_addr_d = hit ? {spr, dy, dx} : rom_addr_q;
    hit1_d     = hit && pix_en;
    v1_d       = pix_en;
    hit2_d     = hit1_q;
    v2_d       = v1_q;
    datao_d    = hit2_q ? rom_data : TRANSPARENT;
    dv_d       = v2_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shadow_q   <= '0;
      active_q   <= '0;
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
      v1_q       <= 1'b0;
      hit2_q     <= 1'b0;
      v2_q       <= 1'b0;
      datao_q    <= '0;
      dv_q       <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      rom_addr_q <= rom_addr_d;
      hit1_q     <= hit1_d;
      v1_q       <= v1_d;
      hit2_q     <= hit2_d;
      v2_q       <= v2_d;
      datao_q    <= datao_d;
      dv_q       <= dv_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign datao       = datao_q;
  assign datao_valid = dv_q;

endmodule
